uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART serial transmit line between NUM_REQ requesters. It accepts bytes through per-requester valid/ready handshakes and frames them as 8N1, LSB first. Bit timing comes from the one-cycle baud_tick pulse produced by the team's baud_gen block; this block has no counter of its own for bit timing. It sits between the on-chip byte sources and the tx pin.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2.
DATA_W, 8, data bits per frame.
ID_W, $clog2(NUM_REQ), width of grant_id (derived localparam).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
baud_tick  in  1  one-clk pulse, once per bit period, from baud_gen.
enable  in  1  high = new grants allowed. Low never aborts a frame in flight.
req_valid  in  NUM_REQ  per-requester byte available. Must be held with stable data until ready.
req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
req_ready  out  NUM_REQ  one-hot, one-clk accept pulse. A transfer occurs when valid & ready.
grant_id  out  ID_W  index of the requester owning the current frame.
busy  out  1  high whenever state != IDLE.
frame_done  out  1  one-clk pulse at the baud_tick that ends a stop bit.
tx  out  1  serial output, registered; idle level is 1.

Behaviour:
- Reset:
  - Asynchronous, active-high; clock is clk.
  - Outputs: tx=1, req_ready=0, grant_id=0, busy=0, frame_done=0.
  - Internal: state=IDLE, rr_ptr=0, shift register=0, bit_cnt=0.
  - Reset during a frame abandons it; no completion pulse is generated.
- Arbitration:
  - Round-robin search starting at rr_ptr.
  - Winner k: req_ready[k] pulses for exactly 1 clk, data is latched into the shift register, grant_id<=k, rr_ptr<=(k+1) mod NUM_REQ.
  - At most one req_ready bit is high in any cycle.
- States and transitions (all bit transitions occur only on cycles where baud_tick=1):
  - IDLE: tx=1. If enable && |req_valid, arbitrate and go to ARM on the same clk edge. baud_tick is ignored in IDLE.
  - ARM: on baud_tick, tx<=0 (start bit), go to START.
  - START: on baud_tick, tx<=shift[0], shift right, bit_cnt<=0, go to DATA.
  - DATA, on baud_tick with bit_cnt==DATA_W-1: tx<=1 (stop bit), go to STOP.
  - DATA, on baud_tick otherwise: tx<=next bit, bit_cnt++.
  - STOP, on baud_tick: frame_done=1.
    - If enable && |req_valid: arbitrate in the same cycle, tx<=0, go to START. This gives back-to-back frames with no idle bit.
    - Otherwise go to IDLE with tx staying 1.
- Timing and latency:
  - Each bit lasts exactly one baud_tick interval.
  - Latency from an IDLE grant to the start bit is up to one baud period.
- Boundary conditions:
  - req_valid dropping before ready is a protocol violation; behaviour in that case is unspecified.
  - enable falling mid-frame: the current frame completes, then the block goes to IDLE.
  - baud_tick coinciding with the grant cycle in IDLE: the tick is not used. The start bit waits for the next tick.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package uart_pkg:
  - State enum: IDLE, ARM, START, DATA, STOP.
  - Constant UART_DATA_W=8.
  - Constants for the tx idle level and the stop-bit level.
- One natural sub-module, rr_arbiter:
  - Combinational round-robin pick from req_valid and rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - rr_ptr update stays in the parent, so pointer advance is tied to an actual accept.

Test Plan:
1. Requester 2 valid with 0xA5, baud_tick every 16 clk -> req_ready=4'b0100 for 1 clk; grant_id=2. tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clk. frame_done pulses once; then busy=0, tx=1.
2. All 4 valid, each holding new data after every accept -> grant order 0,1,2,3,0. No idle bit between frames: the stop bit is followed directly by a start bit.
3. Requester 1 only after a grant to 3 (rr_ptr=0) -> requester 1 is granted. Then requesters 0 and 2 valid together -> 2 wins (rr_ptr=2).
4. enable=0 with valid high -> no req_ready, tx=1, busy=0. Drop enable mid-frame -> the frame finishes with a stop bit, then IDLE even though valid is still high.
5. Assert reset during data bit 4 -> immediate tx=1, busy=0, grant_id=0. After release, the next grant starts search at requester 0.
6. baud_tick in the same cycle as the IDLE grant -> the start bit begins at the following tick, not that one.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and line levels for the UART tx scheduler.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_STOP_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int              k;
    logic [ID_W-1:0] kk;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        kk    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(ptr) + off;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kk = ID_W'(k);
            if (!found && valid[kk]) begin
                found     = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one 8N1 UART tx line.
// All bit timing comes from the external baud_tick pulse.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = UART_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      tx
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    uart_state_t        state;
    logic [ID_W-1:0]    rr_ptr;
    logic [DATA_W-1:0]  shift;
    logic [CNT_W-1:0]   bit_cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic [DATA_W-1:0]  arb_data;
    logic [ID_W-1:0]    next_ptr;
    logic               can_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign can_grant = enable && (|req_valid);
    assign next_ptr  = (arb_idx == LAST_ID) ? '0 : arb_idx + ID_W'(1);

    always_comb begin
        arb_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                arb_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer only advances on an actual accept, never on a bare request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= TX_IDLE_LVL;
            req_ready  <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rr_ptr     <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
        end else begin
            req_ready  <= '0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (can_grant) begin
                        req_ready <= arb_grant;
                        grant_id  <= arb_idx;
                        rr_ptr    <= next_ptr;
                        shift     <= arb_data;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (baud_tick) begin
                        tx    <= TX_START_LVL;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx      <= shift[0];
                        shift   <= {1'b0, shift[DATA_W-1:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx    <= TX_STOP_LVL;
                            state <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        frame_done <= 1'b1;
                        if (can_grant) begin
                            req_ready <= arb_grant;
                            grant_id  <= arb_idx;
                            rr_ptr    <= next_ptr;
                            shift     <= arb_data;
                            tx        <= TX_START_LVL;
                            state     <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
